operand_fwd_ctrl: RTL

- Controller that drives the 3-bit select inputs of the two 64-bit decode-stage operand muxes (operand A, operand B).
- Keeps a 3-entry shadow of in-flight destination registers (EX, MEM, WB). From it the block picks register file, forwarded result, immediate or PC for each operand.
- Detects load-use hazards and issues a one-cycle stall with bubble insertion. Sits in the decode stage next to the operand muxes and the register file.

---
 rtl/operand_fwd_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/operand_fwd_ctrl.sv
// ----------------------------------------------------------------------------
// operand_fwd_ctrl
//
// Decode-stage controller for the two operand muxes (A and B). It keeps a
// shadow of the destination registers still in flight in EX, MEM and WB. From
// that shadow it picks, for each operand, one of these sources:
//   - the register file
//   - a forwarded result
//   - the immediate
//   - the PC
// It also raises a one-cycle stall with bubble insertion on a load-use hazard.
//
// Select encoding:
//   000 regfile, 001 EX, 010 MEM, 011 WB, 100 immediate, 101 PC
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   dec_valid            decode slot holds a real instruction
//   dec_rs1/dec_rs2      source register indices
//   dec_rd               destination register index
//   dec_reg_write        instruction writes dec_rd
//   dec_is_load          instruction is a load
//   dec_use_pc           operand A takes the PC
//   dec_use_imm          operand B takes the immediate
//   pipe_hold            global freeze; tracking state is held
//   flush                squash EX entry and decode (branch redirect)
//   sel_a, sel_b         operand mux selects (combinational)
//   stall                hold PC and decode registers this cycle
//   stall_cnt            (only with OPFWD_PERF_CNT_EN) count of stall cycles
//                        that were not frozen by pipe_hold; wraps
//
// Optional feature macro: OPFWD_PERF_CNT_EN
// ----------------------------------------------------------------------------
module operand_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_reg_write,
  input  logic                  dec_is_load,
  input  logic                  dec_use_pc,
  input  logic                  dec_use_imm,
  input  logic                  pipe_hold,
  input  logic                  flush,
  output logic [SEL_W-1:0]      sel_a,
  output logic [SEL_W-1:0]      sel_b,
  output logic                  stall
`ifdef OPFWD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EX  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(5);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } stage_t;

  stage_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  function automatic logic hit(input stage_t s, input logic [REG_ADDR_W-1:0] rs);
    return s.valid & s.reg_write & (s.rd == rs) & (rs != '0);
  endfunction

  // Youngest producer wins: EX, then MEM, then WB.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (hit(ex_q, rs))       return SEL_EX;
    else if (hit(mem_q, rs)) return SEL_MEM;
    else if (hit(wb_q, rs))  return SEL_WB;
    else                     return SEL_RF;
  endfunction

  logic              stall_raw;
  logic [SEL_W-1:0]  sel_a_raw, sel_b_raw;

  always_comb begin
    sel_a_raw = dec_use_pc  ? SEL_PC  : fwd_sel(dec_rs1);
    sel_b_raw = dec_use_imm ? SEL_IMM : fwd_sel(dec_rs2);
    // The load result is not available until MEM, so an EX load feeding a
    // real register operand costs one bubble.
    stall_raw = dec_valid & ~flush & ex_q.valid & ex_q.is_load &
                ((hit(ex_q, dec_rs1) & ~dec_use_pc) |
                 (hit(ex_q, dec_rs2) & ~dec_use_imm));
    // Outputs are forced to a quiet state while reset is asserted.
    sel_a = reset ? SEL_RF : sel_a_raw;
    sel_b = reset ? SEL_RF : sel_b_raw;
    stall = reset ? 1'b0   : stall_raw;
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!pipe_hold) begin
      mem_d = ex_q;
      wb_d  = mem_q;
      // Both a flush and a stall insert a bubble into EX.
      if (flush || stall_raw) ex_d = '0;
      else                    ex_d = '{valid: dec_valid, rd: dec_rd,
                                       reg_write: dec_reg_write,
                                       is_load: dec_is_load};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef OPFWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_raw && !pipe_hold) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
